// File: rtl/mic_level_meter.sv
// Windowed microphone level meter: reduces the sample stream to a peak or mean
// excess over BASELINE per window, quantises it and tracks a held/decaying peak level.
module mic_level_meter #(
  parameter int SAMPLE_W     = 12,
  parameter int WINDOW_LOG2  = 10,
  parameter int BASELINE     = 2048,
  parameter int LVL_SHIFT    = 7,
  parameter int LEVELS       = 16,
  parameter int LVL_W        = 4,
  parameter int HOLD_WINDOWS = 2
) (
  input  logic                basys_clk,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [SAMPLE_W-1:0] mic_in,
  input  logic                mode,
  output logic [SAMPLE_W-1:0] window_value,
  output logic [LVL_W-1:0]    raw_level,
  output logic [LVL_W-1:0]    peak_level,
  output logic                level_valid,
  output logic                overrun
);

  localparam int SUM_W  = SAMPLE_W + WINDOW_LOG2;
  localparam int HOLD_W = (HOLD_WINDOWS < 1) ? 1 : $clog2(HOLD_WINDOWS + 1);

  typedef enum logic [1:0] {
    ACCUM,
    MAP,
    HOLD
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [WINDOW_LOG2-1:0] count;
  logic [SAMPLE_W-1:0]    max_acc;
  logic [SUM_W-1:0]       sum_acc;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   mode_r;
  logic [SAMPLE_W-1:0]    excess;
  logic [SAMPLE_W-1:0]    value;
  logic [SAMPLE_W-1:0]    shifted;
  logic [LVL_W-1:0]       level;
  logic                   last_sample;

  assign excess      = (mic_in > SAMPLE_W'(BASELINE)) ? mic_in - SAMPLE_W'(BASELINE) : '0;
  // Mean is the sum divided by the power-of-two window, i.e. its upper bits.
  assign value       = mode_r ? sum_acc[SUM_W-1:WINDOW_LOG2] : max_acc;
  assign shifted     = value >> LVL_SHIFT;
  assign level       = (shifted > SAMPLE_W'(LEVELS - 1)) ? LVL_W'(LEVELS - 1) : shifted[LVL_W-1:0];
  assign last_sample = sample_en && (count == {WINDOW_LOG2{1'b1}});

  always_ff @(posedge basys_clk) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    level_valid = 1'b0;
    case (state)
      ACCUM: begin
        if (last_sample) begin
          state_next = MAP;
        end
      end
      MAP: begin
        state_next = HOLD;
      end
      HOLD: begin
        level_valid = 1'b1;
        state_next  = ACCUM;
      end
      default: begin
        state_next = ACCUM;
      end
    endcase
  end

  always_ff @(posedge basys_clk) begin
    if (!rst_n) begin
      count        <= '0;
      max_acc      <= '0;
      sum_acc      <= '0;
      hold_cnt     <= '0;
      mode_r       <= mode;
      window_value <= '0;
      raw_level    <= '0;
      peak_level   <= '0;
      overrun      <= 1'b0;
    end else begin
      // Strobes arriving while the window result is being mapped are lost.
      if (sample_en && (state != ACCUM)) begin
        overrun <= 1'b1;
      end
      case (state)
        ACCUM: begin
          if (sample_en) begin
            count <= count + 1'b1;
            if (mode_r) begin
              sum_acc <= sum_acc + SUM_W'(excess);
            end else if (excess > max_acc) begin
              max_acc <= excess;
            end
          end
        end
        MAP: begin
          window_value <= value;
          raw_level    <= level;
        end
        HOLD: begin
          if (raw_level >= peak_level) begin
            peak_level <= raw_level;
            hold_cnt   <= HOLD_W'(HOLD_WINDOWS);
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
          end else if (peak_level != '0) begin
            peak_level <= peak_level - 1'b1;
          end
          count   <= '0;
          max_acc <= '0;
          sum_acc <= '0;
          mode_r  <= mode;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mic_level_meter.sv
// Directed testbench for mic_level_meter: full windows of known samples with
// hand-computed window value, level, peak-hold/decay, overrun and reset behaviour.
module tb_mic_level_meter;

  logic        basys_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        sample_en = 1'b0;
  logic [11:0] mic_in    = '0;
  logic        mode      = 1'b0;
  logic [11:0] window_value;
  logic [3:0]  raw_level;
  logic [3:0]  peak_level;
  logic        level_valid;
  logic        overrun;

  int tests_run = 0;
  int fail_cnt  = 0;
  int valid_cnt = 0;
  int valid_before;

  mic_level_meter dut (
    .basys_clk   (basys_clk),
    .rst_n       (rst_n),
    .sample_en   (sample_en),
    .mic_in      (mic_in),
    .mode        (mode),
    .window_value(window_value),
    .raw_level   (raw_level),
    .peak_level  (peak_level),
    .level_valid (level_valid),
    .overrun     (overrun)
  );

  always #5 basys_clk = ~basys_clk;

  always @(negedge basys_clk) begin
    if (level_valid === 1'b1) valid_cnt++;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 5 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Alternates a/b strobes every other cycle; mode is changed halfway through.
  task automatic applyStimulus(input logic [11:0] a, input logic [11:0] b, input int n,
                               input logic next_mode);
    for (int i = 0; i < n; i++) begin
      @(negedge basys_clk);
      sample_en = 1'b1;
      mic_in    = i[0] ? b : a;
      if (i == n / 2) mode = next_mode;
      @(negedge basys_clk);
      sample_en = 1'b0;
    end
  endtask

  task automatic applyReset();
    @(negedge basys_clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_en = ~sample_en;
      mic_in    = 12'hFFF;
      @(negedge basys_clk);
      checkOutput("rst_outputs", {10'd0, window_value, raw_level, peak_level, level_valid, overrun}, 0);
    end
    sample_en = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic finishWindow(input string tag, input int exp_win, input int exp_raw, input int exp_peak);
    int lat;
    lat = 0;
    while (level_valid !== 1'b1 && lat < 50) begin
      @(negedge basys_clk);
      sample_en = 1'b0;
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, 1);
    checkOutput({tag, "_win"}, {20'd0, window_value}, exp_win);
    checkOutput({tag, "_raw"}, {28'd0, raw_level}, exp_raw);
    @(negedge basys_clk);
    checkOutput({tag, "_pulse"}, {31'd0, level_valid}, 0);
    checkOutput({tag, "_peak"}, {28'd0, peak_level}, exp_peak);
  endtask

  task automatic runWindow(input string tag, input logic [11:0] a, input logic [11:0] b,
                           input logic next_mode, input logic force_overrun,
                           input int exp_win, input int exp_raw, input int exp_peak);
    applyStimulus(a, b, 1024, next_mode);
    checkOutput({tag, "_map_no_valid"}, {31'd0, level_valid}, 0);
    if (force_overrun) begin
      sample_en = 1'b1;
      mic_in    = 12'hFFF;
    end
    finishWindow(tag, exp_win, exp_raw, exp_peak);
  endtask

  initial begin
    applyReset();
    #1;
    checkOutput("rst_no_valid", valid_cnt, 0);

    runWindow("peak_full", 12'd4095, 12'd4095, 1'b0, 1'b0, 2047, 15, 15);

    for (int i = 0; i < 18; i++) begin
      runWindow("decay", 12'd2048, 12'd2048, (i == 17) ? 1'b1 : 1'b0, 1'b0, 0, 0,
                (i < 2) ? 15 : ((i <= 16) ? 16 - i : 0));
    end

    runWindow("mean_mode", 12'd2048, 12'd3072, 1'b0, 1'b0, 512, 4, 4);
    runWindow("peak_mode", 12'd2048, 12'd3072, 1'b0, 1'b0, 1024, 8, 8);
    runWindow("below_base", 12'd0, 12'd0, 1'b0, 1'b0, 0, 0, 8);

    checkOutput("overrun_clear", {31'd0, overrun}, 0);
    runWindow("ovr_window", 12'd3072, 12'd3072, 1'b0, 1'b1, 1024, 8, 8);
    checkOutput("overrun_set", {31'd0, overrun}, 1);

    valid_before = valid_cnt;
    applyStimulus(12'd4095, 12'd4095, 1023, 1'b0);
    repeat (20) @(negedge basys_clk);
    #1;
    checkOutput("ovr_no_early_valid", valid_cnt - valid_before, 0);
    applyStimulus(12'd4095, 12'd4095, 1, 1'b0);
    finishWindow("ovr_next", 2047, 15, 15);
    checkOutput("overrun_sticky", {31'd0, overrun}, 1);

    applyStimulus(12'd4095, 12'd4095, 500, 1'b0);
    valid_before = valid_cnt;
    applyReset();
    applyStimulus(12'd3072, 12'd3072, 1023, 1'b0);
    repeat (20) @(negedge basys_clk);
    #1;
    checkOutput("rst_mid_no_valid", valid_cnt - valid_before, 0);
    applyStimulus(12'd3072, 12'd3072, 1, 1'b0);
    finishWindow("rst_mid_next", 1024, 8, 8);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
